// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file access controller.
// Used by rf_access_ctrl and its round-robin write arbiter.
package rf_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic SOURSEL_ALU = 1'b0;
    localparam logic SOURSEL_LSU = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_SETUP,
        ST_W_STROBE,
        ST_W_RELEASE,
        ST_R_SETUP,
        ST_R_STROBE,
        ST_R_RELEASE
    } rf_ctrl_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LSU,
        GNT_RD
    } rf_grant_e;

endpackage

// File: rtl/rf_ctrl_rr_arb.sv
// Two-way round-robin arbiter between the ALU and LSU write requesters.
// The pointer remembers which side was granted last and only moves when
// the caller reports that a grant was actually taken (advance_i).
module rf_ctrl_rr_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic reqAlu_i,
    input  logic reqLsu_i,
    input  logic advance_i,
    output logic gntAlu_o,
    output logic gntLsu_o
);
    import rf_ctrl_pkg::*;

    logic lastLsu_q;
    logic lastLsu_d;

    // On a tie the side that was not served last wins; a lone request always wins
    always_comb begin
        gntAlu_o = reqAlu_i && (!reqLsu_i || lastLsu_q);
        gntLsu_o = reqLsu_i && !gntAlu_o;
    end

    // Move the pointer only when the granted request is consumed
    always_comb begin
        lastLsu_d = lastLsu_q;
        if (advance_i && gntAlu_o) begin
            lastLsu_d = SOURSEL_ALU;
        end else if (advance_i && gntLsu_o) begin
            lastLsu_d = SOURSEL_LSU;
        end
    end

    // Pointer starts as "LSU served last" so the ALU wins the first tie
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lastLsu_q <= SOURSEL_LSU;
        end else begin
            lastLsu_q <= lastLsu_d;
        end
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Scheduler in front of register_file: arbitrates the single write port
// between ALU and LSU, serialises decode reads, and sequences the level
// strobes as setup / strobe / release. Readies are combinational; every
// other output is registered.
// Optional feature macro: RF_CTRL_X0_DISCARD_EN (writes to x0 are accepted
// but never strobed into the register file).
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned MAX_WR_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alu_wvalid_i,
    output logic                  alu_wready_o,
    input  logic [REG_ADDR_W-1:0] alu_waddr_i,
    input  logic [REG_DATA_W-1:0] alu_wdata_i,
    input  logic                  lsu_wvalid_i,
    output logic                  lsu_wready_o,
    input  logic [REG_ADDR_W-1:0] lsu_waddr_i,
    input  logic [REG_DATA_W-1:0] lsu_wdata_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [REG_ADDR_W-1:0] rd_raddr_a_i,
    input  logic [REG_ADDR_W-1:0] rd_raddr_b_i,
    output logic                  rd_done_o,
    output logic [REG_DATA_W-1:0] rd_rdata_a_o,
    output logic [REG_DATA_W-1:0] rd_rdata_b_o,
    output logic                  rf_req_ra_o,
    output logic                  rf_req_rb_o,
    output logic                  rf_req_w_o,
    output logic [REG_ADDR_W-1:0] rf_raddr_a_o,
    output logic [REG_ADDR_W-1:0] rf_raddr_b_o,
    output logic [REG_ADDR_W-1:0] rf_waddr_a_o,
    output logic [REG_DATA_W-1:0] rf_wdata_alu_o,
    output logic [REG_DATA_W-1:0] rf_wdata_lsu_o,
    output logic                  rf_soursel_o,
    input  logic [REG_DATA_W-1:0] rf_rdata_a_i,
    input  logic [REG_DATA_W-1:0] rf_rdata_b_i
);

    localparam logic [3:0] STRB_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_WR_BURST);

    rf_ctrl_state_e state_q, state_d;
    logic [3:0]     strbCnt_q, strbCnt_d;
    logic [3:0]     burstCnt_q, burstCnt_d;

    logic                  reqW_q, reqW_d;
    logic                  reqR_q, reqR_d;
    logic                  done_q, done_d;
    logic                  soursel_q, soursel_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [REG_ADDR_W-1:0] raddrA_q, raddrA_d;
    logic [REG_ADDR_W-1:0] raddrB_q, raddrB_d;
    logic [REG_DATA_W-1:0] wdataAlu_q, wdataAlu_d;
    logic [REG_DATA_W-1:0] wdataLsu_q, wdataLsu_d;
    logic [REG_DATA_W-1:0] rdataA_q, rdataA_d;
    logic [REG_DATA_W-1:0] rdataB_q, rdataB_d;

    rf_grant_e             grant;
    logic                  arbAlu;
    logic                  arbLsu;
    logic                  wrGrant;
    logic                  readWins;
    logic                  discard;
    logic [REG_ADDR_W-1:0] wrAddr;

    rf_ctrl_rr_arb u_rr_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .reqAlu_i  (alu_wvalid_i),
        .reqLsu_i  (lsu_wvalid_i),
        .advance_i (wrGrant),
        .gntAlu_o  (arbAlu),
        .gntLsu_o  (arbLsu)
    );

    // Pick at most one requester, only in IDLE and never while reset is held;
    // a pending read overtakes writes once the write burst limit is reached
    always_comb begin
        grant    = GNT_NONE;
        readWins = rd_valid_i && (burstCnt_q == BURST_MAX);
        if (!rst_i && (state_q == ST_IDLE)) begin
            if ((alu_wvalid_i || lsu_wvalid_i) && !readWins) begin
                if (arbAlu) begin
                    grant = GNT_ALU;
                end else if (arbLsu) begin
                    grant = GNT_LSU;
                end
            end else if (rd_valid_i) begin
                grant = GNT_RD;
            end
        end
    end

    assign alu_wready_o = (grant == GNT_ALU);
    assign lsu_wready_o = (grant == GNT_LSU);
    assign rd_ready_o   = (grant == GNT_RD);
    assign wrGrant      = alu_wready_o || lsu_wready_o;
    assign wrAddr       = lsu_wready_o ? lsu_waddr_i : alu_waddr_i;

`ifdef RF_CTRL_X0_DISCARD_EN
    assign discard = wrGrant && (wrAddr == '0);
`else
    assign discard = 1'b0;
`endif

    // Count writes that were granted while a read was kept waiting
    always_comb begin
        burstCnt_d = burstCnt_q;
        if (grant == GNT_RD) begin
            burstCnt_d = '0;
        end else if (wrGrant) begin
            if (!rd_valid_i) begin
                burstCnt_d = '0;
            end else if (burstCnt_q != BURST_MAX) begin
                burstCnt_d = burstCnt_q + 4'd1;
            end
        end
    end

    // Next-state logic: setup, strobe held for STROBE_CYCLES, release
    always_comb begin
        state_d   = state_q;
        strbCnt_d = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (wrGrant) begin
                    state_d = discard ? ST_W_RELEASE : ST_W_SETUP;
                end else if (grant == GNT_RD) begin
                    state_d = ST_R_SETUP;
                end
            end
            ST_W_SETUP: state_d = ST_W_STROBE;
            ST_W_STROBE: begin
                if (strbCnt_q == STRB_LAST) begin
                    state_d = ST_W_RELEASE;
                end else begin
                    strbCnt_d = strbCnt_q + 4'd1;
                end
            end
            ST_W_RELEASE: state_d = ST_IDLE;
            ST_R_SETUP:   state_d = ST_R_STROBE;
            ST_R_STROBE: begin
                if (strbCnt_q == STRB_LAST) begin
                    state_d = ST_R_RELEASE;
                end else begin
                    strbCnt_d = strbCnt_q + 4'd1;
                end
            end
            ST_R_RELEASE: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; payloads load on the grant edge
    // and everything else holds between operations
    always_comb begin
        waddr_d    = waddr_q;
        wdataAlu_d = wdataAlu_q;
        wdataLsu_d = wdataLsu_q;
        soursel_d  = soursel_q;
        raddrA_d   = raddrA_q;
        raddrB_d   = raddrB_q;
        rdataA_d   = rdataA_q;
        rdataB_d   = rdataB_q;
        if (alu_wready_o && !discard) begin
            waddr_d    = alu_waddr_i;
            wdataAlu_d = alu_wdata_i;
            soursel_d  = SOURSEL_ALU;
        end else if (lsu_wready_o && !discard) begin
            waddr_d    = lsu_waddr_i;
            wdataLsu_d = lsu_wdata_i;
            soursel_d  = SOURSEL_LSU;
        end else if (rd_ready_o) begin
            raddrA_d = rd_raddr_a_i;
            raddrB_d = rd_raddr_b_i;
        end
        if ((state_q == ST_R_STROBE) && (state_d == ST_R_RELEASE)) begin
            rdataA_d = rf_rdata_a_i;
            rdataB_d = rf_rdata_b_i;
        end
        reqW_d = (state_d == ST_W_STROBE);
        reqR_d = (state_d == ST_R_STROBE);
        done_d = (state_d == ST_R_RELEASE);
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            strbCnt_q  <= '0;
            burstCnt_q <= '0;
            reqW_q     <= 1'b0;
            reqR_q     <= 1'b0;
            done_q     <= 1'b0;
            soursel_q  <= 1'b0;
            waddr_q    <= '0;
            raddrA_q   <= '0;
            raddrB_q   <= '0;
            wdataAlu_q <= '0;
            wdataLsu_q <= '0;
            rdataA_q   <= '0;
            rdataB_q   <= '0;
        end else begin
            state_q    <= state_d;
            strbCnt_q  <= strbCnt_d;
            burstCnt_q <= burstCnt_d;
            reqW_q     <= reqW_d;
            reqR_q     <= reqR_d;
            done_q     <= done_d;
            soursel_q  <= soursel_d;
            waddr_q    <= waddr_d;
            raddrA_q   <= raddrA_d;
            raddrB_q   <= raddrB_d;
            wdataAlu_q <= wdataAlu_d;
            wdataLsu_q <= wdataLsu_d;
            rdataA_q   <= rdataA_d;
            rdataB_q   <= rdataB_d;
        end
    end

    assign rf_req_w_o     = reqW_q;
    assign rf_req_ra_o    = reqR_q;
    assign rf_req_rb_o    = reqR_q;
    assign rd_done_o      = done_q;
    assign rf_soursel_o   = soursel_q;
    assign rf_waddr_a_o   = waddr_q;
    assign rf_raddr_a_o   = raddrA_q;
    assign rf_raddr_b_o   = raddrB_q;
    assign rf_wdata_alu_o = wdataAlu_q;
    assign rf_wdata_lsu_o = wdataLsu_q;
    assign rd_rdata_a_o   = rdataA_q;
    assign rd_rdata_b_o   = rdataB_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Testbench for rf_access_ctrl (default parameters). A small register-file
// model answers reads; expected writes/reads are queued when requests are
// granted and checked when the strobe or done pulse appears.
// Honours RF_CTRL_X0_DISCARD_EN when the bench is built with it.
module tb_rf_access_ctrl;

`ifdef RF_CTRL_X0_DISCARD_EN
    localparam bit X0_DISCARD = 1'b1;
`else
    localparam bit X0_DISCARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wvalid, alu_wready, lsu_wvalid, lsu_wready;
    logic [4:0]  alu_waddr, lsu_waddr;
    logic [31:0] alu_wdata, lsu_wdata;
    logic        rd_valid, rd_ready, rd_done;
    logic [4:0]  rd_raddr_a, rd_raddr_b;
    logic [31:0] rd_rdata_a, rd_rdata_b;
    logic        rf_req_ra, rf_req_rb, rf_req_w, rf_soursel;
    logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr_a;
    logic [31:0] rf_wdata_alu, rf_wdata_lsu, rf_rdata_a, rf_rdata_b;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] other;
        logic        sel;
        int          due;
    } wrExp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          due;
    } rdExp_t;

    wrExp_t      wrQ[$];
    rdExp_t      rdQ[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    logic [31:0] lastAluData = '0;
    logic [31:0] lastLsuData = '0;
    logic [4:0]  lastWaddr   = '0;
    logic [31:0] mem [32];
    logic        prevW  = 1'b0;
    logic        prevR  = 1'b0;
    int          wWidth = 0;

    rf_access_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .alu_wvalid_i   (alu_wvalid),
        .alu_wready_o   (alu_wready),
        .alu_waddr_i    (alu_waddr),
        .alu_wdata_i    (alu_wdata),
        .lsu_wvalid_i   (lsu_wvalid),
        .lsu_wready_o   (lsu_wready),
        .lsu_waddr_i    (lsu_waddr),
        .lsu_wdata_i    (lsu_wdata),
        .rd_valid_i     (rd_valid),
        .rd_ready_o     (rd_ready),
        .rd_raddr_a_i   (rd_raddr_a),
        .rd_raddr_b_i   (rd_raddr_b),
        .rd_done_o      (rd_done),
        .rd_rdata_a_o   (rd_rdata_a),
        .rd_rdata_b_o   (rd_rdata_b),
        .rf_req_ra_o    (rf_req_ra),
        .rf_req_rb_o    (rf_req_rb),
        .rf_req_w_o     (rf_req_w),
        .rf_raddr_a_o   (rf_raddr_a),
        .rf_raddr_b_o   (rf_raddr_b),
        .rf_waddr_a_o   (rf_waddr_a),
        .rf_wdata_alu_o (rf_wdata_alu),
        .rf_wdata_lsu_o (rf_wdata_lsu),
        .rf_soursel_o   (rf_soursel),
        .rf_rdata_a_i   (rf_rdata_a),
        .rf_rdata_b_i   (rf_rdata_b)
    );

    always #5 clk = ~clk;

    // Cycle counter advanced on every active edge
    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model: level write while the strobe is high, async read
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
    end
    always @(posedge clk) begin
        if (rf_req_w === 1'b1) mem[rf_waddr_a] <= rf_soursel ? rf_wdata_lsu : rf_wdata_alu;
    end
    assign rf_rdata_a = mem[rf_raddr_a];
    assign rf_rdata_b = mem[rf_raddr_b];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue the strobe the bench expects for a granted write
    task automatic pushWrite(input bit isLsu, input logic [4:0] a, input logic [31:0] d, input int g);
        wrExp_t e;
        if (X0_DISCARD && (a == 5'd0)) return;
        e.addr  = a;
        e.data  = d;
        e.sel   = isLsu;
        e.other = isLsu ? lastAluData : lastLsuData;
        e.due   = g + 2;
        wrQ.push_back(e);
        if (isLsu) lastLsuData = d;
        else lastAluData = d;
        lastWaddr = a;
    endtask

    task automatic pushRead(input logic [31:0] a, input logic [31:0] b, input int g);
        rdExp_t e;
        e.a   = a;
        e.b   = b;
        e.due = g + 3;
        rdQ.push_back(e);
    endtask

    // Wait (bounded) for the ready of source 0=ALU, 1=LSU, 2=read
    task automatic applyStimulus(input int src, output int gCyc);
        gCyc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if ((src == 0 && alu_wready) || (src == 1 && lsu_wready) || (src == 2 && rd_ready)) begin
                gCyc = cyc;
                break;
            end
        end
        if (gCyc < 0) checkOutput("grant_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard side: compare each write strobe and read completion
    always @(negedge clk) begin
        prevW  <= rf_req_w;
        prevR  <= rf_req_ra;
        wWidth <= (rf_req_w === 1'b1) ? wWidth + 1 : 0;
        if (prevW === 1'b1 && rf_req_w === 1'b0) checkOutput("wr_strobe_width", 32'(wWidth), 32'd1);
        if (rf_req_w === 1'b1 && prevW === 1'b0) begin
            if (wrQ.size() == 0) begin
                checkOutput("wr_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                wrExp_t e;
                e = wrQ.pop_front();
                checkOutput("wr_addr", 32'(rf_waddr_a), 32'(e.addr));
                checkOutput("wr_soursel", 32'(rf_soursel), 32'(e.sel));
                checkOutput("wr_data", e.sel ? rf_wdata_lsu : rf_wdata_alu, e.data);
                checkOutput("wr_other_bus", e.sel ? rf_wdata_alu : rf_wdata_lsu, e.other);
                checkOutput("wr_strobe_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (rf_req_ra === 1'b1 && prevR === 1'b0) begin
            checkOutput("rd_strobe_pair", 32'(rf_req_rb), 32'd1);
            if (rdQ.size() > 0) checkOutput("rd_strobe_cycle", 32'(cyc), 32'(rdQ[0].due - 1));
        end
        if (rd_done === 1'b1) begin
            if (rdQ.size() == 0) begin
                checkOutput("rd_unexpected_done", 32'd1, 32'd0);
            end else begin
                rdExp_t e;
                e = rdQ.pop_front();
                checkOutput("rd_data_a", rd_rdata_a, e.a);
                checkOutput("rd_data_b", rd_rdata_b, e.b);
                checkOutput("rd_done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g, g2, nW, rdCyc;
        bit gotRd;

        rst = 1'b1;
        alu_wvalid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h11;
        lsu_wvalid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'h22;
        rd_valid = 1'b1;   rd_raddr_a = '0;  rd_raddr_b = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_alu_ready", 32'(alu_wready), 32'd0);
        checkOutput("rst_lsu_ready", 32'(lsu_wready), 32'd0);
        checkOutput("rst_rd_ready", 32'(rd_ready), 32'd0);
        checkOutput("rst_req_w", 32'(rf_req_w), 32'd0);
        checkOutput("rst_req_ra", 32'(rf_req_ra), 32'd0);
        checkOutput("rst_done", 32'(rd_done), 32'd0);
        checkOutput("rst_waddr", 32'(rf_waddr_a), 32'd0);
        checkOutput("rst_soursel", 32'(rf_soursel), 32'd0);
        checkOutput("rst_rdata_a", rd_rdata_a, 32'd0);
        @(posedge clk); #1;
        alu_wvalid = 1'b0; lsu_wvalid = 1'b0; rd_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // First tie after reset goes to ALU, second tie to LSU
        $display("[TB] tie arbitration");
        alu_wvalid = 1'b1; alu_waddr = 5'd4; alu_wdata = 32'h1;
        lsu_wvalid = 1'b1; lsu_waddr = 5'd5; lsu_wdata = 32'h2;
        applyStimulus(0, g);
        checkOutput("tie1_lsu_ready", 32'(lsu_wready), 32'd0);
        pushWrite(1'b0, alu_waddr, alu_wdata, g);
        @(posedge clk); #1;
        alu_waddr = 5'd6; alu_wdata = 32'h3;
        applyStimulus(1, g2);
        checkOutput("tie2_alu_ready", 32'(alu_wready), 32'd0);
        checkOutput("tie_grant_gap", 32'(g2 - g), 32'd4);
        pushWrite(1'b1, lsu_waddr, lsu_wdata, g2);
        @(posedge clk); #1;
        lsu_wvalid = 1'b0;
        applyStimulus(0, g);
        pushWrite(1'b0, alu_waddr, alu_wdata, g);
        @(posedge clk); #1;
        alu_wvalid = 1'b0;

        // Read back the two tied writes
        $display("[TB] read");
        rd_valid = 1'b1; rd_raddr_a = 5'd4; rd_raddr_b = 5'd5;
        applyStimulus(2, g);
        checkOutput("rd_alu_ready", 32'(alu_wready), 32'd0);
        pushRead(32'h1, 32'h2, g);
        @(posedge clk); #1;
        rd_valid = 1'b0;

        // Continuous ALU writes against a waiting read
        $display("[TB] write burst vs pending read");
        alu_wvalid = 1'b1; alu_waddr = 5'd8; alu_wdata = 32'h100;
        rd_valid = 1'b1; rd_raddr_a = 5'd8; rd_raddr_b = 5'd9;
        nW = 0; gotRd = 1'b0; rdCyc = 0;
        for (int n = 0; n < 60 && !gotRd; n++) begin
            @(negedge clk); #1;
            if (alu_wready) begin
                pushWrite(1'b0, alu_waddr, alu_wdata, cyc);
                nW++;
                @(posedge clk); #1;
                alu_waddr = 5'(8 + nW); alu_wdata = 32'h100 + 32'(nW);
            end else if (rd_ready) begin
                pushRead(32'h100, 32'h101, cyc);
                gotRd = 1'b1;
                rdCyc = cyc;
                @(posedge clk); #1;
                rd_valid = 1'b0;
            end
        end
        checkOutput("burst_read_granted", 32'(gotRd), 32'd1);
        checkOutput("burst_write_count", 32'(nW), 32'd4);
        applyStimulus(0, g);
        checkOutput("burst_resume_gap", 32'(g - rdCyc), 32'd4);
        pushWrite(1'b0, alu_waddr, alu_wdata, g);
        @(posedge clk); #1;
        alu_wvalid = 1'b0;

        // Write to x0, then an LSU write as soon as the FSM is idle again
        $display("[TB] write to address 0");
        alu_wvalid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hDEAD;
        applyStimulus(0, g);
        pushWrite(1'b0, alu_waddr, alu_wdata, g);
        @(posedge clk); #1;
        alu_wvalid = 1'b0;
        lsu_wvalid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h33;
        applyStimulus(1, g2);
        checkOutput("x0_next_grant_gap", 32'(g2 - g), X0_DISCARD ? 32'd2 : 32'd4);
        checkOutput("x0_waddr_hold", 32'(rf_waddr_a), 32'(lastWaddr));
        checkOutput("x0_wdata_alu", rf_wdata_alu, lastAluData);
        pushWrite(1'b1, lsu_waddr, lsu_wdata, g2);
        @(posedge clk); #1;
        lsu_wvalid = 1'b0;

        // Reset while the write strobe is high
        $display("[TB] reset during write strobe");
        alu_wvalid = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'h77;
        applyStimulus(0, g);
        pushWrite(1'b0, alu_waddr, alu_wdata, g);
        @(posedge clk); #1;
        alu_wvalid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("strobe_before_reset", 32'(rf_req_w), 32'd1);
        rst = 1'b1;
        alu_wvalid = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'h99;
        @(negedge clk); #1;
        checkOutput("reset_req_w", 32'(rf_req_w), 32'd0);
        checkOutput("reset_req_ra", 32'(rf_req_ra), 32'd0);
        checkOutput("reset_alu_ready", 32'(alu_wready), 32'd0);
        checkOutput("reset_waddr", 32'(rf_waddr_a), 32'd0);
        checkOutput("reset_wdata_alu", rf_wdata_alu, 32'd0);
        @(negedge clk); #1;
        checkOutput("reset_hold_alu_ready", 32'(alu_wready), 32'd0);
        checkOutput("reset_no_done", 32'(rd_done), 32'd0);
        lastAluData = '0;
        lastLsuData = '0;
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'(alu_wready), 32'd1);
        pushWrite(1'b0, alu_waddr, alu_wdata, cyc);
        @(posedge clk); #1;
        alu_wvalid = 1'b0;

        repeat (8) @(negedge clk);
        #1;
        checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'd0);
        checkOutput("rd_queue_drained", 32'(rdQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rf_access_ctrl.md
# rf_access_ctrl

Synchronous scheduler in front of `register_file`. It arbitrates the single write port between the ALU and LSU writeback requesters and serialises read requests from decode. It drives the register file's level-sensitive `req_ra`/`req_rb`/`req_w` strobes with a setup/strobe/release sequence, and returns captured read data with a done pulse.

## Interface
Parameters:
- `STROBE_CYCLES`, default 1 — cycles a request strobe is held high; legal range 1..15.
- `MAX_WR_BURST`, default 4 — maximum consecutive writes granted while a read is pending; legal range 1..15.

Ports:
- `clk_i`  in  1  — single clock.
- `rst_i`  in  1  — reset, synchronous, active-high.
- `alu_wvalid_i` / `alu_wready_o`  in/out  1  — ALU write handshake.
- `alu_waddr_i`  in  5  — ALU write address.
- `alu_wdata_i`  in  32  — ALU write data.
- `lsu_wvalid_i` / `lsu_wready_o`  in/out  1  — LSU write handshake.
- `lsu_waddr_i`  in  5  — LSU write address.
- `lsu_wdata_i`  in  32  — LSU write data.
- `rd_valid_i` / `rd_ready_o`  in/out  1  — read handshake.
- `rd_raddr_a_i`, `rd_raddr_b_i`  in  5  — read addresses.
- `rd_done_o`  out  1  — one-cycle pulse; read data valid.
- `rd_rdata_a_o`, `rd_rdata_b_o`  out  32  — captured read data, held until the next read completes.
- `rf_req_ra_o`, `rf_req_rb_o`, `rf_req_w_o`  out  1  — register file strobes.
- `rf_raddr_a_o`, `rf_raddr_b_o`, `rf_waddr_a_o`  out  5  — register file addresses.
- `rf_wdata_alu_o`, `rf_wdata_lsu_o`  out  32  — register file write data.
- `rf_soursel_o`  out  1  — write source select: 0 = ALU, 1 = LSU.
- `rf_rdata_a_i`, `rf_rdata_b_i`  in  32  — register file read data.

## Operation
- FSM states: IDLE, W_SETUP, W_STROBE, W_RELEASE, R_SETUP, R_STROBE, R_RELEASE. Only one operation is in flight at a time.
- Readies are asserted only in IDLE, and only for the granted requester. Readies are combinational from the valids and are forced to 0 while `rst_i` is high.
- Handshake rules:
  - A requester holds valid and payload stable until it sees ready.
  - A transfer occurs on any cycle where valid and ready are both high.
  - The payload is registered on the transfer cycle.
- Grant priority in IDLE:
  - Writes beat reads, unless `rd_valid_i` is high and `burst_cnt == MAX_WR_BURST`; then the read wins.
  - ALU vs LSU uses round-robin: when both are valid, the one not granted last wins. A lone requester is always granted.
  - The round-robin pointer resets to "LSU last", so ALU wins the first tie.
- `burst_cnt` behaviour:
  - Increments on each write grant while `rd_valid_i` is high, saturating at `MAX_WR_BURST`.
  - Clears on a read grant, or when a write is granted with `rd_valid_i` low.
- Write sequence:
  - W_SETUP: drive `rf_waddr_a_o`, both wdata buses and `rf_soursel_o`; `rf_req_w_o` = 0.
  - W_STROBE: `rf_req_w_o` = 1 for `STROBE_CYCLES` cycles.
  - W_RELEASE: `rf_req_w_o` = 0.
  - Return to IDLE.
  - For the granted source, the wdata bus carries the payload; the other bus keeps its last value.
- Read sequence:
  - Same three phases, using `rf_raddr_a/b_o` and `rf_req_ra_o` + `rf_req_rb_o` together.
  - `rf_rdata_a/b_i` are sampled on the last R_STROBE cycle.
  - `rd_done_o` pulses during R_RELEASE.
- Address, data and soursel outputs hold their values outside an operation.
- Reset values (all registered outputs): 0. State = IDLE, `burst_cnt` = 0.
- Reset mid-operation: the edge with `rst_i` high returns the FSM to IDLE and drops all strobes. The interrupted access is lost and no done pulse is produced.

## Timing
- Grant on edge N. Setup occupies cycle N+1. The strobe is high during cycles N+2 .. N+1+`STROBE_CYCLES`. Release is the following cycle.
- IDLE is re-entered `STROBE_CYCLES`+3 cycles after the grant. With the default, the next grant is possible 4 cycles after the previous one.
- Read latency from `rd_valid_i`&`rd_ready_o` to `rd_done_o` is `STROBE_CYCLES`+2 cycles.
- All outputs except the readies are registered.

## Configuration
- `RF_CTRL_X0_DISCARD_EN`:
  - Defined: a write to address 0 handshakes normally but skips the strobe. The FSM goes IDLE → W_RELEASE → IDLE with `rf_req_w_o` held 0, and `rf_waddr_a_o`/wdata are not updated. The grant still counts for round-robin and `burst_cnt`.
  - Undefined: address 0 is written like any other address.

## Structure
- Package `rf_ctrl_pkg` holds:
  - `REG_ADDR_W` = 5 and `REG_DATA_W` = 32.
  - `SOURSEL_ALU` = 1'b0 and `SOURSEL_LSU` = 1'b1.
  - FSM state enum `rf_ctrl_state_e`.
  - Grant enum `rf_grant_e` (NONE, ALU, LSU, RD).
- Sub-module `rf_ctrl_rr_arb`: 2-way round-robin arbiter with a registered last-grant pointer and an advance-on-grant input.

## Test plan
- ALU write: addr 4, data 0x1 → `rf_soursel_o`=0, `rf_waddr_a_o`=4, `rf_wdata_alu_o`=0x1, one-cycle `rf_req_w_o` 2 cycles after the grant. LSU write: addr 5, data 0x2 → soursel=1, same timing.
- ALU and LSU valid on the same cycle after reset → ALU is granted first, LSU 4 cycles later. A second tie → LSU first.
- Read after those writes: addr a=4, b=5, RF returns 0x1/0x2 → `rd_rdata_a_o`=0x1, `rd_rdata_b_o`=0x2, `rd_done_o` 3 cycles after the handshake.
- Continuous ALU writes plus a pending read, `MAX_WR_BURST`=4 → exactly 4 writes, then the read, then writes resume.
- `rst_i` asserted during W_STROBE → next edge: all strobes 0, FSM in IDLE, readies 0 while reset is held.
- Write to addr 0 with `RF_CTRL_X0_DISCARD_EN` → ready given, `rf_req_w_o` never rises, back in IDLE after 2 cycles. Without the macro → normal strobe.
